// File: rtl/uart_tx_engine.sv
// Serial transmit stage of the APB UART: pops bytes from a FWFT FIFO and sends 8N1-style frames.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  parity_odd,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  txd,
    output logic                  busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] shift_q, shift_n;
    logic [DIV_WIDTH-1:0]  period_q, period_n;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_n;
    logic [BIT_W-1:0]      bit_q, bit_n, bit_inc;
    logic                  txd_q, txd_n;
    logic                  bit_end;
    logic                  pop;
    logic                  last_data;

`ifndef UART_TX_PARITY_EN
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // FIFO handshake: !fifo_empty acts as valid for fifo_dout; fifo_rd_en is the
    // ready/pop strobe and a word transfers on every clk edge where both are high.
    assign bit_end   = (cnt_q == period_q);
    assign last_data = (bit_q == BIT_W'(DATA_WIDTH - 1));
    assign bit_inc   = bit_q + 1'b1;
    assign pop       = rst_n && tx_en && !fifo_empty &&
                       ((state == S_IDLE) || ((state == S_STOP) && bit_end));

    assign fifo_rd_en = pop;
    assign txd        = txd_q;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            shift_q  <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            txd_q    <= 1'b1;
        end else begin
            state    <= state_n;
            shift_q  <= shift_n;
            period_q <= period_n;
            cnt_q    <= cnt_n;
            bit_q    <= bit_n;
            txd_q    <= txd_n;
        end
    end

    always_comb begin
        state_n  = state;
        shift_n  = shift_q;
        period_n = period_q;
        cnt_n    = cnt_q + 1'b1;
        bit_n    = bit_q;
        txd_n    = txd_q;

        case (state)
            S_IDLE: begin
                cnt_n = '0;
                txd_n = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    cnt_n   = '0;
                    bit_n   = '0;
                    txd_n   = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (last_data) begin
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
                        txd_n   = ^shift_q ^ parity_odd;
`else
                        state_n = S_STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        bit_n = bit_inc;
                        txd_n = shift_q[bit_inc];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    cnt_n   = '0;
                    txd_n   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                    txd_n   = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                txd_n   = 1'b1;
            end
        endcase

        // A pop overrides everything: it also covers the zero-gap STOP -> START path.
        if (pop) begin
            state_n  = S_START;
            shift_n  = fifo_dout;
            period_n = baud_div;
            cnt_n    = '0;
            txd_n    = 1'b0;
        end
    end

endmodule
